// File: rtl/vtile_pkg.sv
// rtl/vtile_pkg.sv - shared constants, vector type and lane-slice helper for the vector tile
package vtile_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_LANES     = 4;
  localparam int DEF_NUM_PORTS = 2;

  typedef logic [DEF_LANES-1:0][DEF_WIDTH-1:0] vec_t;

  // LSB of lane `lane` of port `port` in a flat port/lane/element bus
  function automatic int lane_lsb(input int port, input int lane,
                                  input int lanes, input int width);
    return (port * lanes + lane) * width;
  endfunction

endpackage

// File: rtl/vtile_port_fifo2.sv
// rtl/vtile_port_fifo2.sv - one network port's 2-slot vector queue, read via the shared pointer
module vtile_port_fifo2
  import vtile_pkg::*;
#(
  parameter int VW = DEF_LANES * DEF_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [VW-1:0] in_data,
  input  logic          rd_ptr,
  input  logic          pop,
  output logic [1:0]    vld,
  output logic [VW-1:0] head_data
);

  logic [VW-1:0] slot [2];
  logic [1:0]    vld_q;
  logic          wr_ptr;
  logic          wr_en;

  assign in_ready  = !vld_q[wr_ptr];
  assign wr_en     = in_valid && in_ready;
  assign vld       = vld_q;
  assign head_data = slot[rd_ptr];

  // A write only targets an empty slot and a pop only a full one, so they never collide
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld_q  <= 2'b00;
      wr_ptr <= 1'b0;
    end else begin
      if (wr_en) begin
        vld_q[wr_ptr] <= 1'b1;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        vld_q[rd_ptr] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      slot[wr_ptr] <= in_data;
    end
  end

endmodule

// File: rtl/vtile_operand_buf.sv
// rtl/vtile_operand_buf.sv - joins per-port vector queues into one operand set plus config for the vector FU
module vtile_operand_buf
  import vtile_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LANES     = DEF_LANES,
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int CFG_RESET = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             in_valid,
  output logic [NUM_PORTS-1:0]             in_ready,
  input  logic [NUM_PORTS*LANES*WIDTH-1:0] in_data,
  input  logic                             cfg_wen,
  input  logic [WIDTH-1:0]                 cfg_wdata,
  output logic                             cfg_ack,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_PORTS*LANES*WIDTH-1:0] out_data,
  output logic [WIDTH-1:0]                 out_cfg,
  output logic [1:0]                       occupancy
);

  localparam int VW = LANES * WIDTH;
  localparam logic [WIDTH-1:0] CFG_INIT = WIDTH'(CFG_RESET);

  logic                 rd_ptr;
  logic                 pop;
  logic [NUM_PORTS-1:0] vld_s0;
  logic [NUM_PORTS-1:0] vld_s1;
  logic [NUM_PORTS-1:0] head_vld;
  logic                 full_s0;
  logic                 full_s1;
  logic [WIDTH-1:0]     cfg_q;
  logic                 cfg_ack_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [1:0]    port_vld;
    logic [VW-1:0] port_head;

    vtile_port_fifo2 #(.VW(VW)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid[p]),
      .in_ready  (in_ready[p]),
      .in_data   (in_data[lane_lsb(p, 0, LANES, WIDTH) +: VW]),
      .rd_ptr    (rd_ptr),
      .pop       (pop),
      .vld       (port_vld),
      .head_data (port_head)
    );

    assign vld_s0[p] = port_vld[0];
    assign vld_s1[p] = port_vld[1];
    assign out_data[lane_lsb(p, 0, LANES, WIDTH) +: VW] = out_valid ? port_head : '0;
  end

  assign head_vld  = rd_ptr ? vld_s1 : vld_s0;
  assign out_valid = &head_vld;
  assign pop       = out_valid && out_ready;

  assign full_s0   = &vld_s0;
  assign full_s1   = &vld_s1;
  assign occupancy = {full_s0 && full_s1, full_s0 ^ full_s1};

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= 1'b0;
    end else if (pop) begin
      rd_ptr <= ~rd_ptr;
    end
  end

  // Config survives a flush; only reset restores it
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q     <= CFG_INIT;
      cfg_ack_q <= 1'b0;
    end else begin
      cfg_ack_q <= cfg_wen && !flush;
      if (cfg_wen && !flush) begin
        cfg_q <= cfg_wdata;
      end
    end
  end

  assign out_cfg = cfg_q;
  assign cfg_ack = cfg_ack_q;

endmodule

// File: tb/tb_vtile_operand_buf.sv
// tb/tb_vtile_operand_buf.sv - directed self-checking bench for vtile_operand_buf
module tb_vtile_operand_buf;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   in_valid;
  logic [1:0]   in_ready;
  logic [127:0] in_data;
  logic         cfg_wen;
  logic [15:0]  cfg_wdata;
  logic         cfg_ack;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [15:0]  out_cfg;
  logic [1:0]   occupancy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] va, vb, vc, vx1, vx2, vx3;

  always #5 clk = ~clk;

  vtile_operand_buf #(
    .WIDTH(16), .LANES(4), .NUM_PORTS(2), .CFG_RESET(0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cfg_wen   (cfg_wen),
    .cfg_wdata (cfg_wdata),
    .cfg_ack   (cfg_ack),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cfg   (out_cfg),
    .occupancy (occupancy)
  );

  function automatic logic [63:0] vec4(input logic [15:0] l0, input logic [15:0] l1,
                                       input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [63:0] stream_vec(input int port, input int idx);
    logic [15:0] base;
    base = 16'((port + 1) * 16'h100 + idx * 4);
    return vec4(base, base + 16'd1, base + 16'd2, base + 16'd3);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 2'b00; in_data = '0; cfg_wen = 1'b0; cfg_wdata = '0;
    flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // reset state
    chk("rst_in_ready",  128'(in_ready),  128'(2'b11));
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_out_data",  out_data,        128'h0);
    chk("rst_out_cfg",   128'(out_cfg),   128'(16'h0000));
    chk("rst_cfg_ack",   128'(cfg_ack),   128'(1'b0));
    chk("rst_occ",       128'(occupancy), 128'(2'd0));

    // port0 at cycle 0, port1 at cycle 3
    in_valid = 2'b01; in_data = {64'h0, vec4(16'd1, 16'd2, 16'd3, 16'd4)};
    tick();
    in_valid = 2'b00;
    chk("join_p0_only_valid", 128'(out_valid), 128'(1'b0));
    chk("join_p0_only_ready", 128'(in_ready),  128'(2'b11));
    tick(); tick();
    in_valid = 2'b10; in_data = {vec4(16'd5, 16'd6, 16'd7, 16'd8), 64'h0};
    tick();
    in_valid = 2'b00;
    chk("join_valid", 128'(out_valid), 128'(1'b1));
    chk("join_data",  out_data, {vec4(16'd5, 16'd6, 16'd7, 16'd8), vec4(16'd1, 16'd2, 16'd3, 16'd4)});
    chk("join_occ",   128'(occupancy), 128'(2'd1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("join_pop_valid", 128'(out_valid), 128'(1'b0));
    chk("join_pop_occ",   128'(occupancy), 128'(2'd0));
    chk("join_pop_data",  out_data, 128'h0);

    // port0 runs two vectors ahead of an idle port1
    va  = vec4(16'hA0, 16'hA1, 16'hA2, 16'hA3);
    vb  = vec4(16'hB0, 16'hB1, 16'hB2, 16'hB3);
    vc  = vec4(16'hC0, 16'hC1, 16'hC2, 16'hC3);
    vx1 = vec4(16'hD0, 16'hD1, 16'hD2, 16'hD3);
    vx2 = vec4(16'hE0, 16'hE1, 16'hE2, 16'hE3);
    vx3 = vec4(16'hF0, 16'hF1, 16'hF2, 16'hF3);
    out_ready = 1'b1;
    in_valid = 2'b01; in_data = {64'h0, va};
    tick();
    chk("ahead_ready_1", 128'(in_ready), 128'(2'b11));
    in_data = {64'h0, vb};
    tick();
    chk("ahead_ready_2", 128'(in_ready), 128'(2'b10));
    in_data = {64'h0, vc};
    tick();
    chk("ahead_held_ready", 128'(in_ready),  128'(2'b10));
    chk("ahead_held_valid", 128'(out_valid), 128'(1'b0));
    in_valid = 2'b11; in_data = {vx1, vc};
    tick();
    chk("ahead_set1_valid", 128'(out_valid), 128'(1'b1));
    chk("ahead_set1_data",  out_data, {vx1, va});
    chk("ahead_set1_ready", 128'(in_ready), 128'(2'b10));
    in_data = {vx2, vc};
    tick();
    chk("ahead_set2_data",  out_data, {vx2, vb});
    chk("ahead_set2_ready", 128'(in_ready), 128'(2'b11));
    chk("ahead_set2_occ",   128'(occupancy), 128'(2'd1));
    in_valid = 2'b01; in_data = {64'h0, vc};
    tick();
    chk("ahead_c_wait_valid", 128'(out_valid), 128'(1'b0));
    in_valid = 2'b10; in_data = {vx3, 64'h0};
    tick();
    chk("ahead_set3_data", out_data, {vx3, vc});
    in_valid = 2'b00;
    tick();
    chk("ahead_drained", 128'(out_valid), 128'(1'b0));

    // sustained streaming, one set per cycle
    in_valid = 2'b11; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = {stream_vec(1, i), stream_vec(0, i)};
      tick();
      chk($sformatf("stream_valid_%0d", i), 128'(out_valid), 128'(1'b1));
      chk($sformatf("stream_data_%0d", i),  out_data, {stream_vec(1, i), stream_vec(0, i)});
      chk($sformatf("stream_ready_%0d", i), 128'(in_ready), 128'(2'b11));
    end
    in_valid = 2'b00;
    tick();
    out_ready = 1'b0;
    chk("stream_end_valid", 128'(out_valid), 128'(1'b0));
    chk("stream_end_occ",   128'(occupancy), 128'(2'd0));

    // config write concurrent with a pop
    in_valid = 2'b11; in_data = {stream_vec(1, 20), stream_vec(0, 20)};
    tick();
    in_valid = 2'b00;
    chk("cfg_set_valid", 128'(out_valid), 128'(1'b1));
    cfg_wen = 1'b1; cfg_wdata = 16'hA5A5; out_ready = 1'b1;
    #1;
    chk("cfg_popped_sees_old", 128'(out_cfg), 128'(16'h0000));
    tick();
    cfg_wen = 1'b0; out_ready = 1'b0;
    chk("cfg_ack_pulse",  128'(cfg_ack),   128'(1'b1));
    chk("cfg_new_value",  128'(out_cfg),   128'(16'hA5A5));
    chk("cfg_pop_done",   128'(out_valid), 128'(1'b0));
    tick();
    chk("cfg_ack_clear",  128'(cfg_ack),   128'(1'b0));

    // fill both slots, then flush with competing handshakes
    in_valid = 2'b11; in_data = {stream_vec(1, 30), stream_vec(0, 30)};
    tick();
    in_data = {stream_vec(1, 31), stream_vec(0, 31)};
    tick();
    in_valid = 2'b00;
    chk("full_occ",   128'(occupancy), 128'(2'd2));
    chk("full_ready", 128'(in_ready),  128'(2'b00));
    chk("full_data",  out_data, {stream_vec(1, 30), stream_vec(0, 30)});
    flush = 1'b1; in_valid = 2'b11; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 2'b00; out_ready = 1'b0;
    chk("flush_occ",   128'(occupancy), 128'(2'd0));
    chk("flush_valid", 128'(out_valid), 128'(1'b0));
    chk("flush_ready", 128'(in_ready),  128'(2'b11));
    chk("flush_cfg",   128'(out_cfg),   128'(16'hA5A5));
    chk("flush_data",  out_data, 128'h0);

    // mid-stream reset restores config
    in_valid = 2'b11; in_data = {stream_vec(1, 40), stream_vec(0, 40)};
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 2'b00;
    chk("mrst_cfg",   128'(out_cfg),   128'(16'h0000));
    chk("mrst_occ",   128'(occupancy), 128'(2'd0));
    chk("mrst_valid", 128'(out_valid), 128'(1'b0));
    chk("mrst_ready", 128'(in_ready),  128'(2'b11));
    tick();
    chk("mrst_idle_valid", 128'(out_valid), 128'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
